tt_lpf_pi_lock: RTL and testbench

TT_LPF_PI_LOCK -- requirements
Module: tt_lpf_pi_lock

---
 rtl/tt_lpf_pi_lock.sv | 173 +++++++++++++++++
 tb/tb_tt_lpf_pi_lock.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_lpf_pi_lock.sv
// Proportional-integral loop filter for a bang-bang PFD with a lock detector.
// The integrator and the 4-bit gains double as a scan chain for load and readback.
module tt_lpf_pi_lock #(
    parameter int          ACC_W      = 24,
    parameter int          OUT_W      = 16,
    parameter int unsigned KP_RST     = 7,
    parameter int unsigned KI_RST     = 4,
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 8
) (
    input  logic                    i_clk_gen,
    input  logic                    i_rst_n,
    input  logic                    i_up,
    input  logic                    i_down,
    input  logic                    i_hold,
    input  logic                    i_scan_en,
    input  logic                    i_scan_in,
    output logic signed [OUT_W-1:0] o_filtered_control_signal,
    output logic                    o_locked,
    output logic                    o_sat,
    output logic                    o_scan_out
);

    localparam int ZC_W = $clog2(LOCK_CNT + 1);
    localparam int SC_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [ZC_W-1:0] ZC_MAX = ZC_W'(LOCK_CNT);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(UNLOCK_CNT);

    typedef enum logic {StAcquire = 1'b0, StLocked = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [3:0]         r_kp;
    logic [3:0]         r_ki;
    logic [ACC_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_out;
    logic               r_sat;
    logic [ZC_W-1:0]    r_zc;
    logic [SC_W-1:0]    r_sc;
    logic               r_neg;       // sign of the last nonzero error

    logic               w_err_pos;
    logic               w_err_neg;
    logic               w_err_nz;
    logic               w_normal;
    logic [3:0]         w_ki_eff;
    logic [ACC_W:0]     w_acc_ext;
    logic [ACC_W:0]     w_ki_ext;
    logic [ACC_W:0]     w_kp_ext;
    logic [ACC_W:0]     w_acc_sum;
    logic               w_acc_ovf;
    logic [ACC_W-1:0]   w_acc_d;
    logic [ACC_W:0]     w_out_sum;
    logic [ACC_W-OUT_W+1:0] w_out_hi;
    logic               w_out_ovf;
    logic [OUT_W-1:0]   w_out_d;
    logic [ZC_W-1:0]    w_zc_d;
    logic [SC_W-1:0]    w_sc_d;

    // {up,down}: 01 -> +1, 10 -> -1, 00/11 -> 0
    assign w_err_pos = i_down & ~i_up;
    assign w_err_neg = i_up & ~i_down;
    assign w_err_nz  = w_err_pos | w_err_neg;
    assign w_normal  = ~i_scan_en & ~i_hold;

    // Integral gain is halved once locked to cut jitter
    assign w_ki_eff  = (r_state == StLocked) ? (r_ki >> 1) : r_ki;

    // One guard bit is enough: each step adds at most 15
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
    assign w_ki_ext  = {{(ACC_W-3){1'b0}}, w_ki_eff};
    assign w_kp_ext  = {{(ACC_W-3){1'b0}}, r_kp};

    // Integrator and proportional sums with saturation detect
    always_comb begin
        w_acc_sum = w_acc_ext;
        w_out_sum = w_acc_ext;
        if (w_err_pos) begin
            w_acc_sum = w_acc_ext + w_ki_ext;
            w_out_sum = w_acc_ext + w_kp_ext;
        end else if (w_err_neg) begin
            w_acc_sum = w_acc_ext - w_ki_ext;
            w_out_sum = w_acc_ext - w_kp_ext;
        end
    end

    assign w_acc_ovf = w_acc_sum[ACC_W] ^ w_acc_sum[ACC_W-1];
    assign w_acc_d   = !w_acc_ovf ? w_acc_sum[ACC_W-1:0] :
                       w_acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                          {1'b0, {(ACC_W-1){1'b1}}};

    // Output fits iff all bits above the OUT_W sign bit match it
    assign w_out_hi  = w_out_sum[ACC_W:OUT_W-1];
    assign w_out_ovf = ~((&w_out_hi) | ~(|w_out_hi));
    assign w_out_d   = !w_out_ovf ? w_out_sum[OUT_W-1:0] :
                       w_out_sum[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                          {1'b0, {(OUT_W-1){1'b1}}};

    // Zero-run and same-sign-run counters, both saturating
    always_comb begin
        w_zc_d = r_zc;
        if (w_err_nz) begin
            w_zc_d = '0;
        end else if (r_zc != ZC_MAX) begin
            w_zc_d = r_zc + ZC_W'(1);
        end
        w_sc_d = r_sc;
        if (!w_err_nz) begin
            w_sc_d = '0;
        end else if ((r_sc == '0) || (r_neg != w_err_neg)) begin
            // A sign change starts a new run that already has one member
            w_sc_d = SC_W'(1);
        end else if (r_sc != SC_MAX) begin
            w_sc_d = r_sc + SC_W'(1);
        end
    end

    // Lock FSM next state; frozen during scan and hold
    always_comb begin
        w_state_d = r_state;
        if (w_normal) begin
            case (r_state)
                StAcquire: if (w_zc_d == ZC_MAX) w_state_d = StLocked;
                StLocked:  if (w_sc_d == SC_MAX) w_state_d = StAcquire;
                default:   w_state_d = StAcquire;
            endcase
        end
    end

    // Lock FSM state register
    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StAcquire;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Datapath: scan shift has priority, then hold, then normal update
    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kp  <= 4'(KP_RST);
            r_ki  <= 4'(KI_RST);
            r_acc <= '0;
            r_out <= '0;
            r_sat <= 1'b0;
            r_zc  <= '0;
            r_sc  <= '0;
            r_neg <= 1'b0;
        end else if (i_scan_en) begin
            r_kp  <= {r_kp[2:0], i_scan_in};
            r_ki  <= {r_ki[2:0], r_kp[3]};
            r_acc <= {r_acc[ACC_W-2:0], r_ki[3]};
        end else begin
            r_out <= w_out_d;
            if (!i_hold) begin
                r_acc <= w_acc_d;
                r_sat <= w_acc_ovf | w_out_ovf;
                r_zc  <= w_zc_d;
                r_sc  <= w_sc_d;
                if (w_err_nz) begin
                    r_neg <= w_err_neg;
                end
            end
        end
    end

    assign o_filtered_control_signal = r_out;
    assign o_locked                  = (r_state == StLocked);
    assign o_sat                     = r_sat;
    assign o_scan_out                = r_acc[ACC_W-1];

endmodule

// File: tb/tb_tt_lpf_pi_lock.sv
// Directed bench for tt_lpf_pi_lock: vector table plus hand-written sequences.
module tb_tt_lpf_pi_lock;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic up      = 1'b0;
    logic down    = 1'b0;
    logic hold    = 1'b0;
    logic scan_en = 1'b0;
    logic scan_in = 1'b0;
    logic signed [15:0] out;
    logic locked;
    logic sat;
    logic scan_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              up;
        logic              down;
        logic              hold;
        logic signed [15:0] out;
        logic              sat;
        logic              locked;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    tt_lpf_pi_lock #(
        .ACC_W      (24),
        .OUT_W      (16),
        .KP_RST     (7),
        .KI_RST     (4),
        .LOCK_CNT   (64),
        .UNLOCK_CNT (8)
    ) dut (
        .i_clk_gen                 (clk),
        .i_rst_n                   (rst_n),
        .i_up                      (up),
        .i_down                    (down),
        .i_hold                    (hold),
        .i_scan_en                 (scan_en),
        .i_scan_in                 (scan_in),
        .o_filtered_control_signal (out),
        .o_locked                  (locked),
        .o_sat                     (sat),
        .o_scan_out                (scan_out)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic u, input logic d, input logic h);
        up   = u;
        down = d;
        hold = h;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks outputs before any edge arrives
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check({tag, " rst out"}, 32'(out), 0);
        check({tag, " rst sat"}, 32'(sat), 0);
        check({tag, " rst locked"}, 32'(locked), 0);
        check({tag, " rst scan_out"}, 32'(scan_out), 0);
        scan_en = 1'b0;
        up = 1'b0; down = 1'b0; hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Shifts a full 32-bit chain {acc, ki, kp}; returns the old acc seen MSB-first
    task automatic scan(input logic [31:0] chain, output logic [23:0] old_acc);
        old_acc = '0;
        for (int t = 0; t < 32; t++) begin
            scan_en = 1'b1;
            scan_in = chain[31-t];
            if (t < 24) old_acc[23-t] = scan_out;
            @(posedge clk);
            #1;
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    initial begin
        logic [23:0] old;
        logic signed [15:0] pre_out;
        int n;

        //            up  dn  hd   out   sat locked
        vecs[0]  = '{1'b0, 1'b1, 1'b0,  16'sd7,  1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0,  16'sd11, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0,  16'sd15, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0,  16'sd12, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1,  16'sd5,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1,  16'sd5,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0,  16'sd12, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0,  16'sd5,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0,  16'sd8,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0,  16'sd1,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, -16'sd3,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, -16'sd7,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, -16'sd4,  1'b0, 1'b0};

        #3;
        pulse_reset("init");

        // Basic PI response and hold behaviour
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].up, vecs[i].down, vecs[i].hold);
            check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].out));
            check($sformatf("vec%0d sat", i), 32'(sat), 32'(vecs[i].sat));
            check($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].locked));
        end

        // Lock after 64 zero edges; hold must not advance the zero counter
        pulse_reset("lock");
        for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 1'b0);
        check("lock 63 zeros", 32'(locked), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        check("lock hold frozen", 32'(locked), 0);
        step(1'b0, 1'b0, 1'b0);
        check("lock 64th zero", 32'(locked), 1);
        step(1'b0, 1'b1, 1'b0);
        check("locked down1 out", 32'(out), 7);
        step(1'b0, 1'b1, 1'b0);
        check("locked down2 out", 32'(out), 9);
        step(1'b0, 1'b0, 1'b0);
        check("locked half ki acc", 32'(out), 4);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        check("unlock after 7", 32'(locked), 1);
        step(1'b1, 1'b0, 1'b0);
        check("unlock after 8", 32'(locked), 0);
        check("unlock 8th out", 32'(out), -17);
        step(1'b0, 1'b0, 1'b0);
        check("unlock acc", 32'(out), -12);

        // Relock, then reset while locked
        n = 0;
        while (!locked && n < 80) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("relock", 32'(locked), 1);
        check("relock edges", n, 63);
        pulse_reset("locked");
        step(1'b0, 1'b1, 1'b0);
        check("post-lock-rst kp", 32'(out), 7);
        step(1'b0, 1'b1, 1'b0);
        check("post-lock-rst ki", 32'(out), 11);

        // Positive integrator clamp
        pulse_reset("sat");
        scan({24'h7FFFFF, 4'd4, 4'd7}, old);
        check("scan1 old acc", 32'(old), 0);
        check("scan1 out held", 32'(out), 0);
        step(1'b0, 1'b1, 1'b0);
        check("pos clamp out", 32'(out), 32767);
        check("pos clamp sat", 32'(sat), 1);

        // Negative clamp; readback proves acc stayed at max
        scan({24'h800000, 4'd4, 4'd7}, old);
        check("scan2 old acc", 32'(old), 32'h7FFFFF);
        step(1'b1, 1'b0, 1'b0);
        check("neg clamp out", 32'(out), -32768);
        check("neg clamp sat", 32'(sat), 1);

        // Output-only clamp, then clamp release clears o_sat
        pre_out = out;
        scan({24'd32765, 4'd4, 4'd7}, old);
        check("scan3 old acc", 32'(old), 32'h800000);
        check("scan3 out held", 32'(out), 32'(pre_out));
        check("scan3 sat held", 32'(sat), 1);
        step(1'b0, 1'b1, 1'b0);
        check("out clamp out", 32'(out), 32767);
        check("out clamp sat", 32'(sat), 1);
        step(1'b0, 1'b0, 1'b0);
        check("out clamp zero err", 32'(out), 32767);
        step(1'b1, 1'b0, 1'b0);
        check("unclamp out", 32'(out), 32762);
        check("unclamp sat", 32'(sat), 0);

        // Load kp=3, ki=1, acc=0
        scan({24'd0, 4'd1, 4'd3}, old);
        check("scan4 old acc", 32'(old), 32765);
        step(1'b0, 1'b1, 1'b0);
        check("new kp out", 32'(out), 3);
        step(1'b0, 1'b0, 1'b0);
        check("new ki acc", 32'(out), 1);

        // Reset in the middle of a scan
        for (int t = 0; t < 10; t++) begin
            scan_en = 1'b1;
            scan_in = 1'b1;
            @(posedge clk);
            #1;
        end
        pulse_reset("midscan");
        step(1'b0, 1'b1, 1'b0);
        check("post-scan-rst kp", 32'(out), 7);
        step(1'b0, 1'b1, 1'b0);
        check("post-scan-rst ki", 32'(out), 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
